// File: rtl/y86_pkg.sv
// y86_pkg: shared types and constants for the Y86 pipeline memory path.
package y86_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_BEAT0,
        S_F_BEAT1,
        S_M_ACC,
        S_DONE_F,
        S_DONE_M
    } arb_state_e;

    typedef enum logic {GRANT_F, GRANT_M} grant_e;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] SAOK = 4'b1000;
    localparam logic [3:0] SHLT = 4'b0100;
    localparam logic [3:0] SADR = 4'b0010;
    localparam logic [3:0] SINS = 4'b0001;

    // 65-bit sum so an access wrapping past 2^64 is also out of range
    function automatic logic range_err(input logic [63:0] addr, input logic [64:0] len,
                                       input logic [64:0] limit);
        return ({1'b0, addr} + len) > limit;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts cycles spent waiting on memory; expired on the last allowed cycle.
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [15:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? 16'd0 : en ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == 16'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between two-beat fetches and data accesses.
module mem_port_arbiter
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_done,
    output logic [79:0] f_instr,
    output logic        f_err,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_done,
    output logic [63:0] m_rdata,
    output logic        m_err,
    output logic        f_stall_mem,
    output logic        m_stall_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);
    arb_state_e  state_q, state_d;
    grant_e      last_q, last_d;
    logic [79:0] instr_q, instr_d;
    logic [63:0] rdata_q, rdata_d;
    logic        ferr_q, ferr_d, merr_q, merr_d;
    logic        f_oob, m_oob, m_win, expired;

    assign f_oob = range_err(f_addr, 65'd10, 65'(MEM_BYTES));
    assign m_oob = range_err(m_addr, 65'd8, 65'(MEM_BYTES));
    // Round-robin on collision: data wins unless data had the previous grant
    assign m_win = m_req && (!f_req || last_q == GRANT_F);

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!mem_req || mem_ack),
        .en     (mem_req),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= GRANT_F;
            instr_q <= '0;
            rdata_q <= '0;
            ferr_q  <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            ferr_q  <= ferr_d;
            merr_q  <= merr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        ferr_d  = ferr_q;
        merr_d  = merr_q;
        case (state_q)
            S_IDLE: begin
                if (m_win) begin
                    last_d  = GRANT_M;
                    merr_d  = m_oob;
                    rdata_d = '0;
                    state_d = m_oob ? S_DONE_M : S_M_ACC;
                end else if (f_req) begin
                    last_d  = GRANT_F;
                    ferr_d  = f_oob;
                    instr_d = '0;
                    state_d = f_oob ? S_DONE_F : S_F_BEAT0;
                end
            end
            S_F_BEAT0: begin
                if (mem_ack) begin
                    ferr_d  = mem_err;
                    instr_d[63:0] = mem_err ? instr_q[63:0] : mem_rdata;
                    state_d = mem_err ? S_DONE_F : S_F_BEAT1;
                end else if (expired) begin
                    ferr_d  = 1'b1;
                    state_d = S_DONE_F;
                end
            end
            S_F_BEAT1: begin
                if (mem_ack) begin
                    ferr_d  = mem_err;
                    instr_d[79:64] = mem_err ? instr_q[79:64] : mem_rdata[15:0];
                    state_d = S_DONE_F;
                end else if (expired) begin
                    ferr_d  = 1'b1;
                    state_d = S_DONE_F;
                end
            end
            S_M_ACC: begin
                if (mem_ack) begin
                    merr_d  = mem_err;
                    rdata_d = (m_we || mem_err) ? rdata_q : mem_rdata;
                    state_d = S_DONE_M;
                end else if (expired) begin
                    merr_d  = 1'b1;
                    state_d = S_DONE_M;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = state_q inside {S_F_BEAT0, S_F_BEAT1, S_M_ACC};
        mem_we      = (state_q == S_M_ACC) && m_we;
        mem_addr    = state_q == S_F_BEAT0 ? f_addr :
                      state_q == S_F_BEAT1 ? f_addr + 64'd8 :
                      state_q == S_M_ACC   ? m_addr : 64'd0;
        mem_wdata   = (state_q == S_M_ACC) ? m_wdata : 64'd0;
        f_done      = state_q == S_DONE_F;
        m_done      = state_q == S_DONE_M;
        f_stall_mem = f_req && !f_done;
        m_stall_mem = m_req && !m_done;
    end

    assign f_instr = instr_q;
    assign f_err   = ferr_q;
    assign m_rdata = rdata_q;
    assign m_err   = merr_q;
endmodule
